// File: rtl/fp_add_pkg.sv
// Shared types and constants for the double-precision adder datapath.
// Used by the alignment sequencer and its combinational shift step.
package fp_add_pkg;

  localparam int EXP_W     = 11;
  localparam int SIG_W     = 53;
  localparam int ALN_W     = 55;
  localparam int MAX_ALIGN = 56;
  localparam int REM_W     = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    HOLD  = 2'd2
  } align_state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp_operand_t;

  // Any difference of MAX_ALIGN or more already flushes the whole aligned word.
  function automatic logic [REM_W-1:0] clamp_delta(input logic [EXP_W-1:0] d);
    return (d >= EXP_W'(MAX_ALIGN)) ? REM_W'(MAX_ALIGN) : d[REM_W-1:0];
  endfunction

endpackage

// File: rtl/align_step.sv
// One combinational alignment step: right shift of the guarded significand
// plus the OR of every bit that falls off the bottom.
module align_step
  import fp_add_pkg::*;
(
  input  logic [ALN_W-1:0] val_i,
  input  logic [REM_W-1:0] shamt_i,
  output logic [ALN_W-1:0] val_o,
  output logic             sticky_o
);

  logic [ALN_W-1:0] lost_mask;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lost_mask = '1;
    if (shamt_i < REM_W'(ALN_W)) begin
      lost_mask = ~({ALN_W{1'b1}} << shamt_i);
    end
    val_o    = val_i >> shamt_i;
    sticky_o = |(val_i & lost_mask);
  end

endmodule

// File: rtl/fp_align_seq.sv
// Alignment sequencer: picks the larger-exponent operand, then shifts the other
// significand right SHIFT_STEP bits per cycle, folding lost bits into sticky.
module fp_align_seq
  import fp_add_pkg::*;
#(
  parameter int SHIFT_STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sa,
  input  logic             sb,
  input  logic [EXP_W-1:0] ea,
  input  logic [EXP_W-1:0] eb,
  input  logic [SIG_W-1:0] fa,
  input  logic [SIG_W-1:0] fb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sa2,
  output logic             sb2,
  output logic [SIG_W-1:0] fa2,
  output logic [ALN_W-1:0] fb2,
  output logic             sticky,
  output logic [EXP_W-1:0] e_out,
  output logic             eff_sub,
  output logic             swapped
);

  localparam logic [REM_W-1:0] STEP = REM_W'(SHIFT_STEP);

  align_state_t     state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             sa2_q, sa2_d;
  logic             sb2_q, sb2_d;
  logic [SIG_W-1:0] fa2_q, fa2_d;
  logic [ALN_W-1:0] fb2_q, fb2_d;
  logic             sticky_q, sticky_d;
  logic [EXP_W-1:0] e_out_q, e_out_d;
  logic             eff_sub_q, eff_sub_d;
  logic             swapped_q, swapped_d;

  fp_operand_t      op_a, op_b, op_big, op_small;
  logic             swap;
  logic [EXP_W-1:0] delta;
  logic [REM_W-1:0] rem_init;
  logic [REM_W-1:0] step_amt;
  logic [ALN_W-1:0] step_val;
  logic             step_sticky;

  // Operand selection for the accept cycle; equal exponents never swap.
  always_comb begin
    op_a     = '{sign: sa, exp: ea, sig: fa};
    op_b     = '{sign: sb, exp: eb, sig: fb};
    swap     = (eb > ea);
    op_big   = swap ? op_b : op_a;
    op_small = swap ? op_a : op_b;
    delta    = op_big.exp - op_small.exp;
    rem_init = clamp_delta(delta);
    step_amt = (rem_q < STEP) ? rem_q : STEP;
  end

  align_step u_align_step (
    .val_i    (fb2_q),
    .shamt_i  (step_amt),
    .val_o    (step_val),
    .sticky_o (step_sticky)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    sa2_d     = sa2_q;
    sb2_d     = sb2_q;
    fa2_d     = fa2_q;
    fb2_d     = fb2_q;
    sticky_d  = sticky_q;
    e_out_d   = e_out_q;
    eff_sub_d = eff_sub_q;
    swapped_d = swapped_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          swapped_d = swap;
          sa2_d     = op_big.sign;
          sb2_d     = op_small.sign;
          fa2_d     = op_big.sig;
          fb2_d     = {op_small.sig, 2'b00};
          sticky_d  = 1'b0;
          e_out_d   = op_big.exp;
          eff_sub_d = sa ^ sb;
          rem_d     = rem_init;
          state_d   = (rem_init != '0) ? ALIGN : HOLD;
        end
      end
      ALIGN: begin
        fb2_d    = step_val;
        sticky_d = sticky_q | step_sticky;
        rem_d    = rem_q - step_amt;
        if (rem_q == step_amt) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, because the outputs must read zero after reset, not just the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments in clocked blocks keep every flop sampling pre-edge values.
      state_q   <= IDLE;
      rem_q     <= '0;
      sa2_q     <= 1'b0;
      sb2_q     <= 1'b0;
      fa2_q     <= '0;
      fb2_q     <= '0;
      sticky_q  <= 1'b0;
      e_out_q   <= '0;
      eff_sub_q <= 1'b0;
      swapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      sa2_q     <= sa2_d;
      sb2_q     <= sb2_d;
      fa2_q     <= fa2_d;
      fb2_q     <= fb2_d;
      sticky_q  <= sticky_d;
      e_out_q   <= e_out_d;
      eff_sub_q <= eff_sub_d;
      swapped_q <= swapped_d;
    end
  end

  // Handshake flags decode state only, so nothing combinational reaches them from the inputs.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign sa2       = sa2_q;
  assign sb2       = sb2_q;
  assign fa2       = fa2_q;
  assign fb2       = fb2_q;
  assign sticky    = sticky_q;
  assign e_out     = e_out_q;
  assign eff_sub   = eff_sub_q;
  assign swapped   = swapped_q;

endmodule

// File: doc/fp_align_seq.md
# fp_align_seq

Multi-cycle alignment sequencer for the double-precision adder. Accepts two unpacked operands over a valid/ready handshake, decides the operand swap from the exponents, then shifts the smaller-exponent significand right by the exponent difference over several cycles, `SHIFT_STEP` bits per cycle. Shifted-out bits are collected into a sticky bit. It sits between the unpack stage and the significand adder and hands the adder a swapped, aligned operand pair.

## Interface
- `SHIFT_STEP`, default 8: maximum right-shift bits per cycle; legal range 1..56.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand pair is valid.
- `in_ready` out 1: block can accept an operand pair.
- `sa`, `sb` in 1: operand signs.
- `ea`, `eb` in 11: biased exponents.
- `fa`, `fb` in 53: significands, hidden bit included.
- `out_valid` out 1: aligned pair is valid.
- `out_ready` in 1: adder accepts the pair.
- `sa2`, `sb2` out 1: signs after swap (`sa2` belongs to the larger-exponent operand).
- `fa2` out 53: larger-exponent significand, unshifted.
- `fb2` out 55: smaller-exponent significand with 2 guard bits, aligned.
- `sticky` out 1: OR of every bit shifted out of `fb2`.
- `e_out` out 11: larger exponent.
- `eff_sub` out 1: `sa ^ sb`.
- `swapped` out 1: the operands were exchanged (`eb > ea`).

## Operation
- State machine with three states: IDLE, ALIGN, HOLD. Reset value is IDLE.
- `in_ready` is 1 only in IDLE.
- **Accept**: in IDLE, when `in_valid` is 1:
  - `swapped = (eb > ea)`, a strict comparison; equal exponents never swap.
  - `fa2`, `sa2` and `e_out` load from the larger-exponent operand; `sb2` loads from the other operand.
  - `fb2` loads `{smaller_f, 2'b00}`; `sticky` loads 0.
  - `delta = |ea - eb|`, clamped to 56 and held in a 6-bit remaining counter `rem`.
  - Next state is ALIGN if `rem != 0`, otherwise HOLD.
- **ALIGN**: each cycle:
  - `s = min(SHIFT_STEP, rem)`.
  - `fb2 <= fb2 >> s`.
  - `sticky <= sticky | OR(bits shifted out)`.
  - `rem <= rem - s`.
  - When `rem - s == 0`, next state is HOLD.
- **HOLD**: `out_valid` is 1 and all outputs are held stable.
  - On `out_ready` = 1, go to IDLE.
  - On `out_ready` = 0, stay in HOLD with outputs unchanged.
- **Clamp**: any `delta >= 56` shifts `fb2` fully to 0. `sticky` then equals the OR of the smaller significand.
- **Zero/denormal**: exponent 0 is handled numerically as-is; no special-casing here.
- **Reset at any time**: next state is IDLE and any in-flight operation is discarded.
- **Output reset values**:
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `fa2`, `fb2`, `e_out`, `sa2`, `sb2`, `sticky`, `eff_sub`, `swapped` = 0.

## Timing
- Latency from the accept edge to `out_valid` high is `1 + ceil(min(delta,56)/SHIFT_STEP)` cycles:
  - `delta` = 0: 1 cycle.
  - `delta` = 10 with `SHIFT_STEP` = 8: 3 cycles.
  - `delta` ≥ 56 with `SHIFT_STEP` = 8: 8 cycles.
- Minimum initiation interval is latency + 1 cycle (the return through IDLE). No input is accepted while in ALIGN or HOLD.
- `out_valid` deasserts the cycle after a HOLD cycle with `out_ready` = 1.
- Input values are sampled only on the accept edge. Inputs may change freely afterwards.
- No combinational path from `out_ready` or `in_valid` to any output.

## Structure
- **Package `fp_add_pkg`** holds:
  - `EXP_W` = 11, `SIG_W` = 53, `ALN_W` = 55, `MAX_ALIGN` = 56.
  - `align_state_t` enum (IDLE, ALIGN, HOLD).
  - An unpacked-operand struct type (sign, exp, sig).
- **Sub-module `align_step`**: combinational.
  - Inputs: 55-bit value, shift amount 0..56.
  - Outputs: shifted value and the OR of shifted-out bits.
  - Instantiated once; the FSM registers its outputs.

## Test plan
- **Equal exponents**: `ea = eb = 1023`, `fa = 53'h10_0000_0000_0001`, `fb = 53'h18_0000_0000_0000` → `swapped = 0`, `out_valid` 1 cycle after accept, `fb2 = {fb, 2'b00}`, `sticky = 0`, `e_out = 1023`.
- **Swap plus multi-step shift**, `SHIFT_STEP` = 8: `ea = 1000`, `eb = 1010`, `fa` all ones, `sa = 1`, `sb = 0` → `swapped = 1`, `fa2 = fb`, `sa2 = 0`, `sb2 = 1`, `eff_sub = 1`, 2 ALIGN cycles (shift 8 then 2), `fb2 = {fa, 2'b00} >> 10`, `sticky = 1`, `e_out = 1010`, latency 3.
- **Clamp**: `ea = 1100`, `eb = 1000`, `fb = 53'h10_0000_0000_0000` → `fb2 = 0`, `sticky = 1`, latency 8. Same case with `fb = 0` gives `sticky = 0`.
- **Backpressure**: hold `out_ready` low for 5 cycles in HOLD → outputs stable, `in_ready = 0`, `in_valid` ignored. Raising `out_ready` returns to IDLE the next cycle.
- **Reset mid-ALIGN**: assert `rst` on the second ALIGN cycle → next cycle IDLE, `out_valid = 0`, `in_ready = 1`, outputs zero. A following operation completes normally.
- **Back-to-back**: two `delta = 0` ops with `in_valid` and `out_ready` held high → second op accepted 2 cycles after the first; outputs match each op independently.
